// File: rtl/fifo_frame_reader.sv
// Drains a standard-mode FIFO read port into a framed valid/ready stream.
// Reads are paced so the 4-entry buffer always has room for in-flight data.
module fifo_frame_reader #(
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_FRAME_WORDS = 1024,
  parameter int SKID_DEPTH      = 4,
  localparam int LW = $clog2(MAX_FRAME_WORDS + 1),
  localparam int PW = $clog2(SKID_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  input  logic                  fifo_read_data_valid,
  output logic                  fifo_read_enable,
  input  logic [LW-1:0]         frame_words,
  output logic [DATA_WIDTH-1:0] stream_data,
  output logic                  stream_valid,
  input  logic                  stream_ready,
  output logic                  stream_last,
  output logic [15:0]           frames_sent,
  output logic                  protocol_error
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW:0]           occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  en_q, en_d;
  logic                  err_q, err_d;
  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         idx_q, idx_d;
  logic [15:0]           frames_q, frames_d;

  logic [PW+1:0]         pending;
  logic [LW-1:0]         fw_clamped;
  logic [LW-1:0]         len_eff;
  logic                  push;
  logic                  pop;

  // Read pacing from registered state only; en_q holds reads off in reset.
  always_comb begin
    pending = {1'b0, occ_q} + {{(PW+1){1'b0}}, inflight_q};
    fifo_read_enable = en_q && !fifo_empty
                       && (pending < (PW+2)'(3));
  end

  // Head presentation and frame-length selection.
  always_comb begin
    fw_clamped = frame_words;
    if (frame_words == '0) begin
      fw_clamped = LW'(1);
    end else if (frame_words > LW'(MAX_FRAME_WORDS)) begin
      fw_clamped = LW'(MAX_FRAME_WORDS);
    end
    len_eff      = (state_q == IDLE) ? fw_clamped : len_q;
    stream_valid = (occ_q != '0);
    stream_data  = mem_q[rptr_q];
    stream_last  = stream_valid && (idx_q == len_eff - LW'(1));
    push         = fifo_read_data_valid && inflight_q;
    pop          = stream_valid && stream_ready;
    frames_sent    = frames_q;
    protocol_error = err_q;
  end

  // Buffer, pointer, occupancy and frame next-state logic.
  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    inflight_d = fifo_read_enable;
    en_d       = 1'b1;
    err_d      = err_q;
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    frames_d   = frames_q;
    if (fifo_read_data_valid && !inflight_q) begin
      err_d = 1'b1;
    end
    if (push) begin
      mem_d[wptr_q] = fifo_read_data;
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase
    if (state_q == IDLE && stream_valid) begin
      len_d = fw_clamped;
    end
    if (pop) begin
      if (stream_last) begin
        state_d  = IDLE;
        idx_d    = '0;
        frames_d = frames_q + 16'd1;
      end else begin
        state_d = IN_FRAME;
        idx_d   = idx_q + LW'(1);
      end
    end
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
      state_q    <= IDLE;
      len_q      <= LW'(1);
      idx_q      <= '0;
      frames_q   <= '0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      en_q       <= en_d;
      err_q      <= err_d;
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      frames_q   <= frames_d;
    end
  end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench for fifo_frame_reader with a standard-mode FIFO model.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_fifo_frame_reader;

  localparam int DW   = 16;
  localparam int MAXW = 1024;
  localparam int LW   = $clog2(MAXW + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_read_data = '0;
  logic          fifo_read_data_valid = 1'b0;
  logic          fifo_read_enable;
  logic [LW-1:0] frame_words = LW'(4);
  logic [DW-1:0] stream_data;
  logic          stream_valid;
  logic          stream_ready = 1'b0;
  logic          stream_last;
  logic [15:0]   frames_sent;
  logic          protocol_error;

  fifo_frame_reader #(
    .DATA_WIDTH(DW),
    .MAX_FRAME_WORDS(MAXW),
    .SKID_DEPTH(4)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data),
    .fifo_read_data_valid(fifo_read_data_valid),
    .fifo_read_enable(fifo_read_enable),
    .frame_words(frame_words),
    .stream_data(stream_data),
    .stream_valid(stream_valid),
    .stream_ready(stream_ready),
    .stream_last(stream_last),
    .frames_sent(frames_sent),
    .protocol_error(protocol_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [DW-1:0] fmem [0:255];
  int wr_cnt = 0;
  int wr_idx = 0;
  int rd_cnt = 0;
  logic inject = 1'b0;

  assign fifo_empty = (wr_cnt == rd_cnt);

  // Standard-mode FIFO: data appears the cycle after the read strobe.
  always @(posedge clock) begin
    fifo_read_data_valid <= 1'b0;
    if (inject) begin
      fifo_read_data       <= 16'hDEAD;
      fifo_read_data_valid <= 1'b1;
    end else if (fifo_read_enable && !fifo_empty) begin
      fifo_read_data       <= fmem[rd_cnt];
      fifo_read_data_valid <= 1'b1;
      rd_cnt               <= rd_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  int issued = 0;
  int popped = 0;
  logic held_v = 1'b0;
  logic [DW-1:0] held_d = '0;
  logic held_l = 1'b0;

  // Monitor: scoreboard pops, stall stability and read-pacing bound.
  always @(negedge clock) begin
    if (!reset_n) begin
      issued = 0;
      popped = 0;
      held_v = 1'b0;
    end else begin
      if (held_v && stream_valid) begin
        chk("hold_data", 32'(stream_data), 32'(held_d));
        chk("hold_last", 32'(stream_last), 32'(held_l));
      end
      if (fifo_read_enable) begin
        chk("pace_outstanding_lt3", 32'(issued - popped < 3), 32'd1);
        issued++;
      end
      if (stream_valid && stream_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h want none", stream_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", 32'(stream_data), 32'(mon_e.d));
          chk("last", 32'(stream_last), 32'(mon_e.l));
        end
      end
      held_v = stream_valid && !stream_ready;
      held_d = stream_data;
      held_l = stream_last;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic add(input logic [DW-1:0] w, input logic l,
                     input logic expect_it);
    fmem[wr_idx] = w;
    wr_idx++;
    if (expect_it) exp_q.push_back({w, l});
  endtask

  task automatic commit();
    wr_cnt = wr_idx;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !fifo_empty || stream_valid) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(n < 200), 32'd1);
    cyc(1);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_rd_en"}, 32'(fifo_read_enable), 32'd0);
    chk({name, "_valid"}, 32'(stream_valid), 32'd0);
    chk({name, "_last"}, 32'(stream_last), 32'd0);
    chk({name, "_data"}, 32'(stream_data), 32'd0);
    chk({name, "_frames"}, 32'(frames_sent), 32'd0);
    chk({name, "_err"}, 32'(protocol_error), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    #2 reset_n = 1'b0;
    #1 chk_reset_outs("rst0");
    cyc(2);
    reset_n = 1'b1;
    cyc(2);

    // T1: 8 words, 4-word frames, always ready
    frame_words  = LW'(4);
    stream_ready = 1'b1;
    for (int i = 1; i <= 8; i++) add(16'(i), (i % 4) == 0, 1'b1);
    commit();
    @(negedge clock);
    chk("t1_rd_en", 32'(fifo_read_enable), 32'd1);
    chk("t1_valid_c0", 32'(stream_valid), 32'd0);
    @(negedge clock);
    chk("t1_valid_c1", 32'(stream_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("t1_back_to_back", 32'(stream_valid), 32'd1);
    end
    @(negedge clock);
    chk("t1_valid_end", 32'(stream_valid), 32'd0);
    @(posedge clock);
    #1;
    drain("t1");
    chk("t1_frames", 32'(frames_sent), 32'd2);

    // T2: ready toggling
    for (int i = 0; i < 8; i++) add(16'h0011 + 16'(i), (i % 4) == 3, 1'b1);
    commit();
    for (int i = 0; i < 24; i++) begin
      stream_ready = (i % 2) == 0;
      cyc(1);
    end
    stream_ready = 1'b1;
    drain("t2");
    chk("t2_frames", 32'(frames_sent), 32'd4);

    // T3: frame_words 0, 1, 3
    frame_words = LW'(0);
    add(16'h0021, 1'b1, 1'b1);
    commit();
    drain("t3a");
    frame_words = LW'(1);
    add(16'h0022, 1'b1, 1'b1);
    commit();
    drain("t3b");
    frame_words = LW'(3);
    add(16'h0023, 1'b0, 1'b1);
    add(16'h0024, 1'b0, 1'b1);
    add(16'h0025, 1'b1, 1'b1);
    commit();
    drain("t3c");
    chk("t3_frames", 32'(frames_sent), 32'd7);

    // T3: frame_words 3 -> 7 after the first transfer
    add(16'h0031, 1'b0, 1'b1);
    add(16'h0032, 1'b0, 1'b1);
    add(16'h0033, 1'b1, 1'b1);
    commit();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(stream_valid && stream_ready) && n < 50);
    chk("t3_first_xfer_timeout", 32'(n < 50), 32'd1);
    @(posedge clock);
    #1;
    frame_words = LW'(7);
    drain("t3d");
    for (int i = 0; i < 7; i++) add(16'h0041 + 16'(i), i == 6, 1'b1);
    commit();
    drain("t3e");
    chk("t3_frames2", 32'(frames_sent), 32'd9);

    // T4: FIFO empty mid-frame for 10 cycles
    frame_words = LW'(4);
    add(16'h0051, 1'b0, 1'b1);
    add(16'h0052, 1'b0, 1'b1);
    commit();
    drain("t4a");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t4_gap_valid", 32'(stream_valid), 32'd0);
    end
    @(posedge clock);
    #1;
    add(16'h0053, 1'b0, 1'b1);
    add(16'h0054, 1'b1, 1'b1);
    commit();
    drain("t4b");
    chk("t4_frames", 32'(frames_sent), 32'd10);

    // T5: read-data-valid without a read
    chk("t5_err_before", 32'(protocol_error), 32'd0);
    inject = 1'b1;
    cyc(1);
    inject = 1'b0;
    cyc(2);
    chk("t5_err_set", 32'(protocol_error), 32'd1);
    chk("t5_no_output", 32'(stream_valid), 32'd0);
    cyc(5);
    chk("t5_err_held", 32'(protocol_error), 32'd1);

    // T6: reset mid-frame with 2 words buffered
    stream_ready = 1'b0;
    frame_words  = LW'(4);
    add(16'h0061, 1'b0, 1'b1);
    add(16'h0062, 1'b0, 1'b0);
    add(16'h0063, 1'b0, 1'b0);
    commit();
    cyc(6);
    chk("t6_valid_pre", 32'(stream_valid), 32'd1);
    stream_ready = 1'b1;
    cyc(1);
    stream_ready = 1'b0;
    cyc(2);
    chk("t6_buffered", 32'(stream_valid), 32'd1);
    reset_n = 1'b0;
    #1 chk_reset_outs("t6_rst");
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    chk("t6_frames_after", 32'(frames_sent), 32'd0);
    chk("t6_valid_after", 32'(stream_valid), 32'd0);
    frame_words  = LW'(2);
    stream_ready = 1'b1;
    add(16'h0071, 1'b0, 1'b1);
    add(16'h0072, 1'b1, 1'b1);
    commit();
    drain("t6");
    chk("t6_frames_new", 32'(frames_sent), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
